// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcode, forwarding and FSM types for the execute stage
package ex_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11,
    OP_MULH = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_mul(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/ex_iter_mul.sv
// rtl/ex_iter_mul.sv - iterative signed multiplier, MUL_STEP bits per cycle
// Shift-add on magnitudes; the sign is applied to the full product on output.
module ex_iter_mul
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2*XLEN-1:0] product_o
);

  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CW    = $clog2(STEPS);

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q;
  logic [XLEN-1:0]   mplr_q;
  logic [XLEN-1:0]   a_mag, b_mag;

  assign a_mag = a_i[XLEN-1] ? -a_i : a_i;
  assign b_mag = b_i[XLEN-1] ? -b_i : b_i;

  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (mplr_q[k]) acc_d = acc_d + (mcand_q << k);
    end
  end

  assign done_o    = busy_q && (cnt_q == CW'(STEPS - 1));
  assign busy_o    = busy_q;
  assign product_o = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      neg_q   <= a_i[XLEN-1] ^ b_i[XLEN-1];
      acc_q   <= '0;
      mcand_q <= {{XLEN{1'b0}}, a_mag};
      mplr_q  <= b_mag;
    end else if (busy_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << MUL_STEP;
      mplr_q  <= mplr_q >> MUL_STEP;
      cnt_q   <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - execute stage: forwarding, ALU, EX/MEM register
// EX_STAGE_MUL_EN adds the iterative MUL/MULH path and its IDLE/BUSY/DONE FSM.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RADDR    = 5,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic             use_imm,
  input  logic             dst_rd,
  input  logic [XLEN-1:0]  rs_data,
  input  logic [XLEN-1:0]  rt_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [RADDR-1:0] rs,
  input  logic [RADDR-1:0] rt,
  input  logic [RADDR-1:0] rd,
  input  logic [1:0]       wb_ctl,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             wb_regwrite,
  input  logic [RADDR-1:0] wb_dest,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             mem_hold,
  output logic             stall_o,
  output logic             out_valid,
  output logic [1:0]       out_wb,
  output logic             out_memr,
  output logic             out_memw,
  output logic [XLEN-1:0]  out_addr,
  output logic [XLEN-1:0]  out_wdata,
  output logic [RADDR-1:0] out_dest,
  output logic             out_zero
);

  localparam int SHW = $clog2(XLEN);

  op_e             op_w;
  fwd_e            fwd_a, fwd_b;
  logic [XLEN-1:0] opa, opb_fwd, opb, alu_res, res_d;
  logic [SHW-1:0]  shamt;
  logic            load, stall;

  logic             out_valid_q, out_memr_q, out_memw_q, out_zero_q;
  logic [1:0]       out_wb_q;
  logic [XLEN-1:0]  out_addr_q, out_wdata_q;
  logic [RADDR-1:0] out_dest_q;

  assign op_w = op_e'(op);

  // EX/MEM wins over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (out_valid_q && out_wb_q[1] && out_dest_q == rs && rs != '0) fwd_a = FWD_MEM;
    else if (wb_regwrite && wb_dest == rs && rs != '0)               fwd_a = FWD_WB;
    if (out_valid_q && out_wb_q[1] && out_dest_q == rt && rt != '0) fwd_b = FWD_MEM;
    else if (wb_regwrite && wb_dest == rt && rt != '0)               fwd_b = FWD_WB;
  end

  always_comb begin
    case (fwd_a)
      FWD_MEM: opa = out_addr_q;
      FWD_WB:  opa = wb_data;
      default: opa = rs_data;
    endcase
    case (fwd_b)
      FWD_MEM: opb_fwd = out_addr_q;
      FWD_WB:  opb_fwd = wb_data;
      default: opb_fwd = rt_data;
    endcase
  end

  assign opb   = use_imm ? imm : opb_fwd;
  assign shamt = opb[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_w)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_NOR:  alu_res = ~(opa | opb);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      OP_SLL:  alu_res = opa << shamt;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
      OP_MUL, OP_MULH: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  state_e            state_q, state_d;
  logic              mul_start, mul_busy, mul_done, ld_mul, mulh_q;
  logic [2*XLEN-1:0] mul_prod;

  ex_iter_mul #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (opa),
    .b_i       (opb),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    stall     = 1'b0;
    load      = 1'b0;
    ld_mul    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (mem_hold) begin
            stall = 1'b1;
          end else if (is_mul(op_w)) begin
            mul_start = 1'b1;
            stall     = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (mul_done || !mul_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (mem_hold) begin
          stall = 1'b1;
        end else begin
          load    = 1'b1;
          ld_mul  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mulh_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mul_start) mulh_q <= (op_w == OP_MULH);
    end
  end

  assign res_d = !ld_mul ? alu_res :
                 mulh_q  ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
`else
  assign stall = in_valid && mem_hold;
  assign load  = in_valid && !mem_hold;
  assign res_d = alu_res;
`endif

  // A frozen downstream keeps EX/MEM intact; otherwise a non-load is a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_wb_q    <= '0;
      out_memr_q  <= 1'b0;
      out_memw_q  <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      out_dest_q  <= '0;
      out_zero_q  <= 1'b0;
    end else if (!mem_hold) begin
      out_valid_q <= load;
      if (load) begin
        out_wb_q    <= wb_ctl;
        out_memr_q  <= mem_rd;
        out_memw_q  <= mem_wr;
        out_addr_q  <= res_d;
        out_wdata_q <= opb_fwd;
        out_dest_q  <= dst_rd ? rd : rt;
        out_zero_q  <= (res_d == '0);
      end
    end
  end

  assign stall_o   = stall;
  assign out_valid = out_valid_q;
  assign out_wb    = out_wb_q;
  assign out_memr  = out_memr_q;
  assign out_memw  = out_memw_q;
  assign out_addr  = out_addr_q;
  assign out_wdata = out_wdata_q;
  assign out_dest  = out_dest_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - directed vector bench for ex_stage_mc (XLEN=32, MUL_STEP=1)
module tb_ex_stage_mc;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, use_imm, dst_rd, mem_rd, mem_wr, wb_regwrite, mem_hold;
  logic [3:0]  op;
  logic [31:0] rs_data, rt_data, imm, wb_data;
  logic [4:0]  rs, rt, rd, wb_dest;
  logic [1:0]  wb_ctl;
  logic        stall_o, out_valid, out_memr, out_memw, out_zero;
  logic [1:0]  out_wb;
  logic [31:0] out_addr, out_wdata;
  logic [4:0]  out_dest;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage_mc #(.XLEN(32), .RADDR(5), .MUL_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .use_imm(use_imm),
    .dst_rd(dst_rd), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .rs(rs), .rt(rt), .rd(rd), .wb_ctl(wb_ctl), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .wb_regwrite(wb_regwrite), .wb_dest(wb_dest), .wb_data(wb_data),
    .mem_hold(mem_hold), .stall_o(stall_o), .out_valid(out_valid), .out_wb(out_wb),
    .out_memr(out_memr), .out_memw(out_memw), .out_addr(out_addr),
    .out_wdata(out_wdata), .out_dest(out_dest), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_e         op;
    logic        use_imm;
    logic        dst_rd;
    logic [4:0]  rs;
    logic [31:0] rs_data;
    logic [4:0]  rt;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        wbrw;
    logic [4:0]  wbd;
    logic [31:0] wbdat;
    logic [31:0] exp_addr;
    logic [4:0]  exp_dest;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input op_e o, input logic ui, input logic drd,
                              input logic [4:0] a_r, input logic [31:0] a_d,
                              input logic [4:0] b_r, input logic [31:0] b_d,
                              input logic [31:0] im, input logic wrw,
                              input logic [4:0] wd, input logic [31:0] wdat,
                              input logic [31:0] ea, input logic [4:0] ed,
                              input logic [31:0] ew);
    vec_t v;
    v.op = o; v.use_imm = ui; v.dst_rd = drd;
    v.rs = a_r; v.rs_data = a_d; v.rt = b_r; v.rt_data = b_d; v.imm = im;
    v.wbrw = wrw; v.wbd = wd; v.wbdat = wdat;
    v.exp_addr = ea; v.exp_dest = ed; v.exp_wdata = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e o, input logic [4:0] a_r, input logic [31:0] a_d,
                       input logic [4:0] b_r, input logic [31:0] b_d, input logic ui,
                       input logic [31:0] im, input logic [4:0] d, input logic [1:0] wbc);
    in_valid = 1'b1; op = o; rs = a_r; rs_data = a_d; rt = b_r; rt_data = b_d;
    use_imm = ui; imm = im; rd = d; dst_rd = 1'b1; wb_ctl = wbc;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

`ifdef EX_STAGE_MUL_EN
  task automatic wait_done(output int n, output int bad);
    n = 0;
    bad = 0;
    while (stall_o && n < 100) begin
      n++;
      if (out_valid) bad++;
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n, bad;

    in_valid = 0; op = 0; use_imm = 0; dst_rd = 1; rs_data = 0; rt_data = 0; imm = 0;
    rs = 0; rt = 0; rd = 0; wb_ctl = 0; mem_rd = 0; mem_wr = 0; wb_regwrite = 0;
    wb_dest = 0; wb_data = 0; mem_hold = 0;

    vecs[0]  = mk(OP_ADD,  1, 1, 1, 32'd5,        2, 32'h11,       32'hFFFFFFF9, 0, 0, 0, 32'hFFFFFFFE, 3, 32'h11);
    vecs[1]  = mk(OP_SUB,  0, 1, 1, 32'd10,       2, 32'd10,       0, 0, 0, 0, 32'h0,        3, 32'd10);
    vecs[2]  = mk(OP_AND,  0, 1, 1, 32'hF0F0F0F0, 2, 32'hFF00FF00, 0, 0, 0, 0, 32'hF000F000, 3, 32'hFF00FF00);
    vecs[3]  = mk(OP_OR,   0, 1, 1, 32'hF0F0F0F0, 2, 32'h0F0F0000, 0, 0, 0, 0, 32'hFFFFF0F0, 3, 32'h0F0F0000);
    vecs[4]  = mk(OP_XOR,  0, 1, 1, 32'hAAAA5555, 2, 32'hFFFF0000, 0, 0, 0, 0, 32'h55555555, 3, 32'hFFFF0000);
    vecs[5]  = mk(OP_NOR,  0, 1, 1, 32'h0000FFFF, 2, 32'h00FF0000, 0, 0, 0, 0, 32'hFF000000, 3, 32'h00FF0000);
    vecs[6]  = mk(OP_SLT,  0, 1, 1, 32'hFFFFFFFF, 2, 32'd1,        0, 0, 0, 0, 32'd1,        3, 32'd1);
    vecs[7]  = mk(OP_SLTU, 0, 1, 1, 32'hFFFFFFFF, 2, 32'd1,        0, 0, 0, 0, 32'd0,        3, 32'd1);
    vecs[8]  = mk(OP_SLL,  0, 1, 1, 32'd1,        2, 32'h1F,       0, 0, 0, 0, 32'h80000000, 3, 32'h1F);
    vecs[9]  = mk(OP_SLL,  0, 1, 1, 32'd3,        2, 32'h21,       0, 0, 0, 0, 32'd6,        3, 32'h21);
    vecs[10] = mk(OP_SRL,  0, 1, 1, 32'h80000000, 2, 32'd4,        0, 0, 0, 0, 32'h08000000, 3, 32'd4);
    vecs[11] = mk(OP_SRA,  0, 1, 1, 32'h80000000, 2, 32'd4,        0, 0, 0, 0, 32'hF8000000, 3, 32'd4);
    vecs[12] = mk(OP_ADD,  0, 1, 1, 32'hFFFFFFFF, 2, 32'd1,        0, 0, 0, 0, 32'd0,        3, 32'd1);
    vecs[13] = mk(OP_ADD,  0, 0, 1, 32'd1,        7, 32'd2,        0, 0, 0, 0, 32'd3,        7, 32'd2);
    vecs[14] = mk(OP_ADD,  0, 1, 9, 32'd1,        2, 32'd5,        0, 1, 9, 32'd100, 32'd105, 3, 32'd5);
    vecs[15] = mk(OP_ADD,  1, 1, 1, 32'd3,        6, 32'h99,       0, 1, 6, 32'h20,  32'd3,   3, 32'h20);
    vecs[16] = mk(OP_SRA,  1, 1, 1, 32'h80000000, 2, 32'd5,        32'h1F, 0, 0, 0, 32'hFFFFFFFF, 3, 32'd5);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_wb", out_wb, 0);
    chk("rst_memr", out_memr, 0);
    chk("rst_memw", out_memw, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_wdata", out_wdata, 0);
    chk("rst_dest", out_dest, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_stall", stall_o, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      v = vecs[i];
      in_valid = 1; op = v.op; use_imm = v.use_imm; dst_rd = v.dst_rd;
      rs = v.rs; rs_data = v.rs_data; rt = v.rt; rt_data = v.rt_data; imm = v.imm;
      rd = 5'd3; wb_ctl = 2'b00; mem_rd = i[0]; mem_wr = i[1];
      wb_regwrite = v.wbrw; wb_dest = v.wbd; wb_data = v.wbdat;
      tick();
      chk($sformatf("v%0d_addr", i), out_addr, v.exp_addr);
      chk($sformatf("v%0d_zero", i), out_zero, (v.exp_addr == 0));
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_dest", i), out_dest, v.exp_dest);
      chk($sformatf("v%0d_wdata", i), out_wdata, v.exp_wdata);
      chk($sformatf("v%0d_ctl", i), {out_wb, out_memr, out_memw}, {2'b00, i[0], i[1]});
    end

    // EX/MEM forward outranks a stale MEM/WB value for r3
    wb_regwrite = 0;
    issue(OP_ADD, 1, 32'd10, 2, 32'd0, 1, 32'd5, 3, 2'b10);
    tick();
    chk("fw_first_addr", out_addr, 15);
    issue(OP_SUB, 3, 32'h77, 3, 32'h77, 0, 32'd0, 4, 2'b10);
    wb_regwrite = 1; wb_dest = 3; wb_data = 32'h55;
    tick();
    chk("fw_sub_addr", out_addr, 0);
    chk("fw_sub_zero", out_zero, 1);
    chk("fw_sub_wdata", out_wdata, 15);
    chk("fw_sub_dest", out_dest, 4);

    // r0 never forwarded
    wb_regwrite = 0;
    issue(OP_ADD, 1, 32'h40, 2, 32'd0, 1, 32'd2, 0, 2'b10);
    tick();
    chk("r0_prod_addr", out_addr, 32'h42);
    issue(OP_ADD, 0, 32'd7, 2, 32'd0, 1, 32'd1, 5, 2'b10);
    wb_regwrite = 1; wb_dest = 0; wb_data = 32'h99;
    tick();
    chk("r0_nofwd_addr", out_addr, 8);

    // downstream hold on a single-cycle op
    wb_regwrite = 0;
    issue(OP_ADD, 1, 32'h100, 2, 32'd0, 1, 32'd1, 6, 2'b10);
    mem_hold = 1;
    #1;
    chk("hold_stall", stall_o, 1);
    tick();
    chk("hold_addr", out_addr, 8);
    chk("hold_dest", out_dest, 5);
    mem_hold = 0;
    #1;
    chk("hold_rel_stall", stall_o, 0);
    tick();
    chk("hold_rel_addr", out_addr, 32'h101);
    chk("hold_rel_valid", out_valid, 1);

    // bubble
    in_valid = 0;
    tick();
    chk("bubble_valid", out_valid, 0);
    chk("bubble_addr", out_addr, 32'h101);

`ifdef EX_STAGE_MUL_EN
    issue(OP_MULH, 1, 32'hFFFFFFFF, 2, 32'd2, 0, 32'd0, 7, 2'b10);
    #1;
    wait_done(n, bad);
    chk("mulh_stall_cycles", n, 33);
    chk("mulh_busy_valid", bad, 0);
    chk("mulh_done_valid", out_valid, 0);
    tick();
    chk("mulh_valid", out_valid, 1);
    chk("mulh_addr", out_addr, 32'hFFFFFFFF);
    chk("mulh_dest", out_dest, 7);
    in_valid = 0;
    tick();
    chk("mulh_one_shot", out_valid, 0);

    issue(OP_MUL, 1, 32'd7, 2, 32'hFFFFFFFD, 0, 32'd0, 8, 2'b00);
    #1;
    wait_done(n, bad);
    chk("mul_stall_cycles", n, 33);
    tick();
    chk("mul_addr", out_addr, 32'hFFFFFFEB);
    chk("mul_zero", out_zero, 0);

    issue(OP_MUL, 1, 32'd6, 2, 32'd7, 0, 32'd0, 9, 2'b00);
    #1;
    wait_done(n, bad);
    chk("mulhold_stall_cycles", n, 33);
    mem_hold = 1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mulhold_stall%0d", c), stall_o, 1);
      tick();
      chk($sformatf("mulhold_valid%0d", c), out_valid, 0);
    end
    mem_hold = 0;
    #1;
    chk("mulhold_rel_stall", stall_o, 0);
    tick();
    chk("mulhold_valid", out_valid, 1);
    chk("mulhold_addr", out_addr, 42);
    in_valid = 0;
    tick();
    chk("mulhold_no_dup", out_valid, 0);

    issue(OP_MUL, 1, 32'd5, 2, 32'd5, 0, 32'd0, 10, 2'b00);
    #1;
    repeat (5) tick();
    chk("busy_stall", stall_o, 1);
`else
    issue(OP_MUL, 1, 32'd3, 2, 32'd4, 0, 32'd0, 7, 2'b00);
    #1;
    chk("nomul_stall", stall_o, 0);
    tick();
    chk("nomul_valid", out_valid, 1);
    chk("nomul_addr", out_addr, 0);
    chk("nomul_zero", out_zero, 1);
    issue(OP_MULH, 1, 32'd3, 2, 32'd4, 0, 32'd0, 8, 2'b00);
    mem_hold = 1;
    #1;
    chk("nomul_hold_stall", stall_o, 1);
    tick();
    chk("nomul_hold_dest", out_dest, 7);
    mem_hold = 0;
    tick();
    chk("nomul_rel_dest", out_dest, 8);
    issue(OP_ADD, 1, 32'd40, 2, 32'd2, 1, 32'd2, 10, 2'b00);
    tick();
    chk("pre_rst_addr", out_addr, 42);
`endif

    // asynchronous reset away from the clock edge
    rst = 0;
    in_valid = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_addr", out_addr, 0);
    chk("arst_dest", out_dest, 0);
    chk("arst_stall", stall_o, 0);
    #1;
    rst = 1;
    issue(OP_ADD, 1, 32'd2, 2, 32'd0, 1, 32'd3, 11, 2'b00);
    #1;
    chk("post_rst_stall", stall_o, 0);
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_addr", out_addr, 5);
    in_valid = 0;
    repeat (40) tick();
    chk("post_rst_quiet", out_valid, 0);
    chk("post_rst_addr_hold", out_addr, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
